// File: rtl/sfx_pkg.sv
// Shared types and default constants for the sound-effect voices.
// The LFSR seed and taps are only used by voices built with SFX_NOISE_EN.
package sfx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int START_INC   = 1024;
    localparam int MIN_INC     = 128;
    localparam int SWEEP_STEP  = 4;
    localparam int AMP_MAX     = 'h3000;
    localparam int DECAY_SHIFT = 8;
    localparam int DUR_SAMPLES = 4800;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
    endfunction

endpackage

// File: rtl/sfx_shot_voice_if.sv
// Sample-request handshake between the codec side and a sound-effect voice.
// The codec side pulses sample_req; the voice returns a held sample and busy.
interface sfx_shot_voice_if #(
    parameter int SAMPLE_W = 16
);
    logic                sample_req;
    logic [SAMPLE_W-1:0] audio_output;
    logic                busy;

    modport master (output sample_req, input audio_output, input busy);
    modport slave  (input sample_req, output audio_output, output busy);
endinterface

// File: rtl/sfx_trig_sync.sv
// Two-flop synchroniser for an asynchronous trigger level plus a registered
// rising-edge detector that emits a one-cycle start pulse.
module sfx_trig_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_trigger,
    output logic o_start
);
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_vld1;
    logic r_vld2;
    logic r_armed;

    // NOTE: a trigger already high when reset releases is not an edge; the
    // detector arms only after it has seen a genuinely sampled low level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_vld1  <= 1'b0;
            r_vld2  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= i_trigger;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_vld1  <= 1'b1;
            r_vld2  <= r_vld1;
            if (r_vld2 && !r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_start = r_sync2 & ~r_sync3 & r_armed;

endmodule

// File: rtl/sfx_shot_voice.sv
// "Shoot" effect voice: square wave with downward pitch sweep and exponential
// decay, one sample per codec request. Define SFX_NOISE_EN to mix in LFSR noise.
module sfx_shot_voice #(
    parameter int SAMPLE_W    = 16,
    parameter int PHASE_W     = 16,
    parameter int START_INC   = sfx_pkg::START_INC,
    parameter int MIN_INC     = sfx_pkg::MIN_INC,
    parameter int SWEEP_STEP  = sfx_pkg::SWEEP_STEP,
    parameter int AMP_MAX     = sfx_pkg::AMP_MAX,
    parameter int DECAY_SHIFT = sfx_pkg::DECAY_SHIFT,
    parameter int DUR_SAMPLES = sfx_pkg::DUR_SAMPLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    sfx_shot_voice_if.slave   bus
);
    import sfx_pkg::*;

    localparam int CNT_W = $clog2(DUR_SAMPLES + 1);

    state_t              r_state;
    logic [PHASE_W-1:0]  r_phase;
    logic [PHASE_W-1:0]  r_inc;
    logic [SAMPLE_W-1:0] r_amp;
    logic [CNT_W-1:0]    r_count;
    logic [SAMPLE_W-1:0] r_audio;
    logic                r_busy;

    logic                w_start;
    logic [PHASE_W-1:0]  w_phase_n;
    logic [PHASE_W-1:0]  w_inc_n;
    logic [SAMPLE_W-1:0] w_amp_n;
    logic [SAMPLE_W-1:0] w_square;
    logic [SAMPLE_W-1:0] w_sample;

    sfx_trig_sync u_trig_sync (
        .clk       (clk),
        .reset     (reset),
        .i_trigger (trigger),
        .o_start   (w_start)
    );

    // The sweep clamps before subtracting, so the increment never underflows.
    always_comb begin
        w_phase_n = r_phase + r_inc;
        w_inc_n   = (r_inc >= PHASE_W'(MIN_INC + SWEEP_STEP))
                  ? r_inc - PHASE_W'(SWEEP_STEP)
                  : PHASE_W'(MIN_INC);
        w_amp_n   = r_amp - (r_amp >> DECAY_SHIFT);
        w_square  = w_phase_n[PHASE_W-1] ? -r_amp : r_amp;
    end

`ifdef SFX_NOISE_EN
    localparam int MIX_W = SAMPLE_W + 8;
    localparam logic signed [MIX_W-1:0] SAT_HI = MIX_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [MIX_W-1:0] SAT_LO = -SAT_HI - MIX_W'(1);

    logic [15:0]              r_lfsr;
    logic [15:0]              w_lfsr_n;
    logic signed [MIX_W-1:0]  w_noise;
    logic signed [MIX_W-1:0]  w_mix;

    always_comb begin
        w_lfsr_n = lfsr_step(r_lfsr);
        w_noise  = MIX_W'($signed(w_lfsr_n) >>> 3)
                 * MIX_W'($signed({1'b0, r_amp >> 12}));
        w_mix    = MIX_W'($signed(w_square)) + w_noise;
        if (w_mix > SAT_HI) begin
            w_sample = SAMPLE_W'(SAT_HI);
        end else if (w_mix < SAT_LO) begin
            w_sample = SAMPLE_W'(SAT_LO);
        end else begin
            w_sample = SAMPLE_W'(w_mix);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_lfsr <= LFSR_SEED;
        end else if (bus.sample_req && r_state == PLAY) begin
            r_lfsr <= w_lfsr_n;
        end
    end
`else
    assign w_sample = w_square;
`endif

    // NOTE: every register here is sequential state, so only non-blocking
    // assignments are used; start is checked first so it wins over sample_req.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_inc   <= '0;
            r_amp   <= '0;
            r_count <= '0;
            r_audio <= '0;
            r_busy  <= 1'b0;
        end else if (w_start) begin
            r_state <= PLAY;
            r_phase <= '0;
            r_inc   <= PHASE_W'(START_INC);
            r_amp   <= SAMPLE_W'(AMP_MAX);
            r_count <= CNT_W'(DUR_SAMPLES);
            r_busy  <= 1'b1;
        end else if (bus.sample_req) begin
            case (r_state)
                PLAY: begin
                    r_phase <= w_phase_n;
                    r_audio <= w_sample;
                    r_inc   <= w_inc_n;
                    r_amp   <= w_amp_n;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_audio <= '0;
                end
            endcase
        end
    end

    assign bus.audio_output = r_audio;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_sfx_shot_voice.sv
// Scoreboard bench for sfx_shot_voice: a behavioural model pushes the expected
// sample for every request, and the DUT output is popped and compared after the edge.
module tb_sfx_shot_voice;

    logic clk = 1'b0;
    logic reset;
    logic trigger;

    sfx_shot_voice_if #(.SAMPLE_W(16)) bus ();

    sfx_shot_voice dut (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];

    bit          m_busy;
    logic [15:0] m_phase;
    int          m_inc;
    int          m_amp;
    int          m_count;
    logic [15:0] m_out;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_start();
        m_busy  = 1'b1;
        m_phase = 16'd0;
        m_inc   = 1024;
        m_amp   = 'h3000;
        m_count = 4800;
    endtask

    task automatic model_req();
        if (m_busy) begin
            m_phase = m_phase + 16'(m_inc);
            m_out   = m_phase[15] ? 16'(-m_amp) : 16'(m_amp);
            m_inc   = (m_inc - 4 < 128) ? 128 : m_inc - 4;
            m_amp   = m_amp - (m_amp >> 8);
            m_count = m_count - 1;
            if (m_count == 0) m_busy = 1'b0;
        end else begin
            m_out = 16'd0;
        end
        exp_q.push_back(m_out);
    endtask

    task automatic do_req(input string tag);
        logic [15:0] e;
        @(negedge clk);
        bus.sample_req = 1'b1;
        model_req();
        @(negedge clk);
        bus.sample_req = 1'b0;
        e = exp_q.pop_front();
        check(tag, {16'd0, bus.audio_output}, {16'd0, e});
        check({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, m_busy});
    endtask

    // Leaves trigger high at a negedge; the synchronised start lands 3 posedges later.
    task automatic raise_trigger();
        @(negedge clk);
        trigger = 1'b0;
        repeat (5) @(negedge clk);
        trigger = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] prev;
        reset          = 1'b1;
        trigger        = 1'b0;
        bus.sample_req = 1'b0;
        m_busy         = 1'b0;
        m_out          = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_audio", {16'd0, bus.audio_output}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_inc", {16'd0, dut.r_inc}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) do_req("idle_req");

        // Start latency: busy rises after the third posedge following the edge.
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        check("lat_p1_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("lat_p2_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("lat_p3_busy", {31'd0, bus.busy}, 32'd1);
        model_start();

        for (int k = 1; k <= 4801; k++) begin
            do_req("play");
            if (k == 1) begin
                check("first_sample", {16'd0, bus.audio_output}, 32'h3000);
                check("inc_after_1", {16'd0, dut.r_inc}, 32'd1020);
            end
            if (k == 2)    check("second_sample", {16'd0, bus.audio_output}, 32'h2FD0);
            if (k == 223)  check("inc_223", {16'd0, dut.r_inc}, 32'd132);
            if (k == 224)  check("inc_224", {16'd0, dut.r_inc}, 32'd128);
            if (k == 4000) check("inc_4000", {16'd0, dut.r_inc}, 32'd128);
            if (k == 4799) check("busy_4799", {31'd0, bus.busy}, 32'd1);
            if (k == 4800) check("busy_4800", {31'd0, bus.busy}, 32'd0);
            if (k == 4801) check("sample_4801", {16'd0, bus.audio_output}, 32'd0);
        end

        // Retrigger after 2000 samples: busy must stay high throughout.
        raise_trigger();
        repeat (3) @(negedge clk);
        model_start();
        for (int k = 1; k <= 2000; k++) do_req("pre_retrig");
        @(negedge clk);
        trigger = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("retrig_busy_lo", {31'd0, bus.busy}, 32'd1);
        end
        trigger = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("retrig_busy_hi", {31'd0, bus.busy}, 32'd1);
        end
        model_start();
        check("retrig_count", {19'd0, dut.r_count}, 32'd4800);
        do_req("retrig");
        check("retrig_first", {16'd0, bus.audio_output}, 32'h3000);

        // start and sample_req on the same edge: output holds, registers reload.
        raise_trigger();
        @(negedge clk);
        @(negedge clk);
        bus.sample_req = 1'b1;
        prev = m_out;
        @(negedge clk);
        bus.sample_req = 1'b0;
        model_start();
        check("same_cycle_hold", {16'd0, bus.audio_output}, {16'd0, prev});
        check("same_cycle_busy", {31'd0, bus.busy}, 32'd1);
        do_req("after_same");
        check("after_same_first", {16'd0, bus.audio_output}, 32'h3000);

        // Reset at sample 100 with the trigger still held high.
        for (int k = 2; k <= 99; k++) do_req("pre_reset");
        @(negedge clk);
        reset          = 1'b1;
        bus.sample_req = 1'b1;
        @(negedge clk);
        bus.sample_req = 1'b0;
        check("midrst_audio", {16'd0, bus.audio_output}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_inc", {16'd0, dut.r_inc}, 32'd0);
        m_busy = 1'b0;
        m_out  = 16'd0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("held_trig_busy", {31'd0, bus.busy}, 32'd0);
        do_req("held_trig_req");

        raise_trigger();
        repeat (3) @(negedge clk);
        check("new_edge_busy", {31'd0, bus.busy}, 32'd1);
        model_start();
        do_req("new_edge");
        check("new_edge_first", {16'd0, bus.audio_output}, 32'h3000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sfx_shot_voice.md
Name: sfx_shot_voice

Overview:
- Upstream sample source for the audio-effects stage. Synthesises the "shoot" sound effect as a square wave with a downward pitch sweep and an exponential amplitude decay.
- Produces one signed 16-bit sample per codec sample request and holds it for the effects stage / codec DAC path.
- Runs in the audio clock domain. The shoot trigger arrives from game logic in another domain.

Parameters:
- SAMPLE_W, 16: output sample width, two's complement.
- PHASE_W, 16: phase accumulator width; wraps modulo 2^PHASE_W.
- START_INC, 1024: phase increment loaded on trigger.
- MIN_INC, 128: floor for the phase increment during the sweep.
- SWEEP_STEP, 4: amount subtracted from the increment per sample.
- AMP_MAX, 16'h3000: initial amplitude, unsigned, must be < 2^(SAMPLE_W-1).
- DECAY_SHIFT, 8: per sample, amp <= amp - (amp >> DECAY_SHIFT).
- DUR_SAMPLES, 4800: effect length in samples (100 ms at 48 kHz).

Ports:
- clk  in  1  audio clock; single clock for the block.
- reset  in  1  synchronous, active-high.
- trigger  in  1  asynchronous level from game logic; a rising edge starts or restarts the effect.
- sample_req  in  1  one-cycle pulse; the codec wants the next sample.
- audio_output  out  SAMPLE_W  current sample, registered, held between requests.
- busy  out  1  high while the effect is playing.

Behaviour:
- Reset: state IDLE, audio_output 0, busy 0, phase 0, inc 0, amp 0, count 0, synchroniser flops 0.
- Trigger path: 2-flop synchroniser, then a registered rising-edge detect. start = sync2 & ~sync3. Latency from an async edge to start is 3 clk.
- FSM state IDLE:
  - audio_output is driven to 0 on every sample_req.
  - On start: load phase 0, inc START_INC, amp AMP_MAX, count DUR_SAMPLES, go to PLAY, busy 1.
- FSM state PLAY, on sample_req (1-clk latency, audio_output updates on the next edge):
  - phase_n = phase + inc, truncated to PHASE_W bits.
  - audio_output = phase_n[MSB] ? -amp : +amp, sign-extended to SAMPLE_W.
  - inc <= max(inc - SWEEP_STEP, MIN_INC), with no underflow.
  - amp <= amp - (amp >> DECAY_SHIFT).
  - count <= count - 1.
- End of effect: on the sample_req where count == 1, output that sample, then go to IDLE and set busy 0. The next sample_req outputs 0.
- start during PLAY (retrigger): reload all registers as above and stay in PLAY.
- start and sample_req in the same cycle: start wins. Registers are reloaded and audio_output holds its previous value; the first new sample is emitted on the next sample_req.
- sample_req with no start: no state change other than those listed above.
- Amplitude cannot go negative. It decays toward 0 and stops changing once amp >> DECAY_SHIFT == 0.
- reset asserted mid-PLAY: all registers return to their reset values on that edge; any pending edge in the synchroniser is discarded.

Optional Feature:
- Macro: SFX_NOISE_EN.
- Defined:
  - Adds a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset and on start.
  - The LFSR steps once per PLAY sample_req.
  - The sample is (square ± amp) + (lfsr_signed >>> 3 scaled by amp >> 12), saturated to the SAMPLE_W signed range.
- Undefined: pure square output, no LFSR logic.

Decomposition:
- Package sfx_pkg holds:
  - state enum {IDLE, PLAY};
  - default localparams START_INC, MIN_INC, SWEEP_STEP, AMP_MAX, DECAY_SHIFT, DUR_SAMPLES;
  - LFSR seed and tap constant.
- Sub-module: sfx_trig_sync, the 2-flop synchroniser plus rising-edge pulse generator. It is reused by any future sound-effect voices.

Test Plan:
- Reset then 10 sample_req pulses with trigger low -> audio_output stays 0, busy 0.
- Trigger rising edge, then first sample_req -> start seen 3 clk after the edge. First sample = +16'h3000 (phase 1024, MSB 0). Second sample = +16'h2FD0, and the internal inc = 1020 after the first sample.
- Full playback with requests every 1000 clk -> busy falls right after the 4800th sample. Sample 4801 = 0. inc clamps at 128 after sample 224 and stays there.
- Retrigger at sample 2000 -> next sample is +16'h3000 again, count restarts at 4800, busy never drops.
- start and sample_req in the same cycle -> audio_output unchanged that edge. The next sample_req gives +16'h3000.
- reset asserted at sample 100 of PLAY -> next edge audio_output 0, busy 0. A trigger held high through the reset release does not start the effect until a new rising edge.
